// File: rtl/jups_io_pkg.sv
// Shared types and helpers for the operator input path.
package jups_io_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_REL
    } in_fsm_t;

    localparam int unsigned IN_DATA_W = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/input_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
module input_fifo
    import jups_io_pkg::*;
#(
    parameter int unsigned DATA_W     = IN_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(FIFO_DEPTH):0]  count
);

    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/input_port_ctrl.sv
// Debounced pushbutton capture of the switch word into a FWFT FIFO for the core's In instruction.
// Optional status outputs (ovf, level) are built only when IN_PORT_STATUS_EN is defined.
module input_port_ctrl
    import jups_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned DATA_W          = IN_DATA_W
) (
    input  logic                        Clock,
    input  logic                        n_reset,
    input  logic                        Button,
    input  logic [DATA_W-1:0]           Switches,
    input  logic                        rd_req,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        stall,
    output logic                        pending,
    output logic                        ovf,
    output logic [clog2(FIFO_DEPTH):0]  level
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic              btn_meta, btn_s;
    logic [DATA_W-1:0] sw_meta, sw_s;
    in_fsm_t           state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              push;
    logic              fifo_full, fifo_empty;
    logic [clog2(FIFO_DEPTH):0] fifo_count;

    // Button idles high, so its synchronizer resets to the released level.
    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            btn_meta <= Button;
            btn_s    <= btn_meta;
            sw_meta  <= Switches;
            sw_s     <= sw_meta;
        end
    end

    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push    = 1'b0;
        pending = 1'b0;
        case (state)
            S_IDLE: begin
                if (!btn_s) begin
                    state_n = S_PRESS;
                    cnt_n   = '0;
                end
            end
            S_PRESS: begin
                if (btn_s) begin
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_HELD;
                    push    = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_HELD: begin
                pending = 1'b1;
                if (btn_s) begin
                    state_n = S_REL;
                    cnt_n   = '0;
                end
            end
            S_REL: begin
                pending = 1'b1;
                if (!btn_s) begin
                    state_n = S_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    input_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (n_reset),
        .push    (push),
        .wr_data (sw_s),
        .pop     (rd_req),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign stall    = rd_req & fifo_empty;

`ifdef IN_PORT_STATUS_EN
    logic ovf_q;

    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            ovf_q <= 1'b0;
        end else if (push & fifo_full & ~rd_req) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf   = ovf_q;
    assign level = fifo_count;
`else
    logic unused_status;
    assign unused_status = ^{fifo_full, fifo_count};
    assign ovf   = 1'b0;
    assign level = '0;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Randomized press/read bench with a queue-based reference model and a decoupled scoreboard monitor.
module tb_input_port_ctrl;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          Button;
    logic [W-1:0]  Switches;
    logic          rd_req;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          stall;
    logic          pending;
    logic          ovf;
    logic [2:0]    level;

    always #5 clk = ~clk;

    input_port_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH),
        .DATA_W          (W)
    ) dut (
        .Clock    (clk),
        .n_reset  (n_reset),
        .Button   (Button),
        .Switches (Switches),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .stall    (stall),
        .pending  (pending),
        .ovf      (ovf),
        .level    (level)
    );

    typedef struct {
        int          edge_n;
        logic [W-1:0] val;
    } push_ev_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    push_ev_t     push_q[$];
    logic [W-1:0] model_q[$];
    bit           ovf_m      = 1'b0;
    int           rd_pct     = 0;
    int           force_edge = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reader: random rd_req, plus a single forced request aimed at a chosen edge.
    initial begin
        rd_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_req = (cyc + 1 == force_edge) ||
                     ((rd_pct > 0) && (int'($urandom_range(99, 0)) < rd_pct));
        end
    end

    // Monitor: compares outputs against the model, then advances the model by one edge.
    initial begin
        bit           has;
        bit           pop_now;
        bit           full_before;
        logic [W-1:0] head;
        push_ev_t     ev;
        forever begin
            @(negedge clk);
            if (n_reset) begin
                has  = (model_q.size() > 0);
                head = has ? model_q[0] : '0;
                check("rd_valid", rd_valid, has);
                check("stall", stall, rd_req && !has);
                check("rd_data", rd_data, head);
`ifdef IN_PORT_STATUS_EN
                check("ovf", ovf, ovf_m);
                check("level", level, model_q.size());
`else
                check("ovf_tied", ovf, 0);
                check("level_tied", level, 0);
`endif
                pop_now     = rd_req && has;
                full_before = (model_q.size() == DEPTH);
                if (pop_now) void'(model_q.pop_front());
                while (push_q.size() > 0 && push_q[0].edge_n <= cyc) begin
                    ev = push_q.pop_front();
                    check("push_sched", ev.edge_n, cyc + 1);
                end
                if (push_q.size() > 0 && push_q[0].edge_n == cyc + 1) begin
                    ev = push_q.pop_front();
                    if (full_before && !pop_now) ovf_m = 1'b1;
                    else model_q.push_back(ev.val);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold Button low for L sampling edges (optionally bounce after acceptance), then release for G edges.
    task automatic press(input logic [W-1:0] val, input int L, input int blip, input int L2,
                         input int G, input bit pop_on_push);
        Switches = val;
        Button   = 1'b0;
        if (L >= D + 1) begin
            push_q.push_back(push_ev_t'{cyc + 3 + D, val});
            if (pop_on_push) force_edge = cyc + 3 + D;
        end
        tick(L);
        if (L >= D + 3) check("pending_held", pending, 1);
        if (L <= D)     check("pending_glitch", pending, 0);
        if (blip > 0) begin
            Button = 1'b1;
            tick(blip);
            Button = 1'b0;
            tick(L2);
            check("pending_bounce", pending, 1);
        end
        Button = 1'b1;
        tick(G);
        check("pending_idle", pending, 0);
        Switches = W'($urandom);
    endtask

    task automatic drain();
        rd_pct = 100;
        tick(2 * DEPTH);
        rd_pct = 0;
        tick(2);
    endtask

    initial begin
        int kind;
        int len;
        n_reset  = 1'b0;
        Button   = 1'b1;
        Switches = '0;
        #23;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_pending", pending, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick(3);

        // Core reads an empty port: stall, then a press satisfies it.
        rd_pct = 100;
        tick(3);
        check("stall_empty", stall, 1);
        press(16'h0042, D + 4, 0, 0, D + 4, 1'b0);
        rd_pct = 0;
        tick(2);

        press(16'h1234, D - 1, 0, 0, D + 4, 1'b0);
        press(16'h5678, D, 0, 0, D + 4, 1'b0);
        press(16'hA5C3, 20, 0, 0, D + 4, 1'b0);
        check("single_valid", rd_valid, 1);
        check("single_data", rd_data, 16'hA5C3);
        drain();

        // Full FIFO with a pop landing on the same edge as the fifth push.
        for (int i = 1; i <= 4; i++) press(W'(i), D + 2, 0, 0, D + 4, 1'b0);
        press(16'd5, D + 2, 0, 0, D + 4, 1'b1);
        drain();

        // Overflow: fifth push dropped.
        for (int i = 1; i <= 5; i++) press(W'(i), D + 2, 0, 0, D + 4, 1'b0);
        drain();

        for (int n = 0; n < 40; n++) begin
            rd_pct = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(80, 10));
            kind   = int'($urandom_range(3, 0));
            case (kind)
                0: press(W'($urandom), int'($urandom_range(D, 1)), 0, 0, D + 4 + int'($urandom_range(6, 0)), 1'b0);
                1: press(W'($urandom), D + 1, 0, 0, D + 4 + int'($urandom_range(6, 0)), 1'b0);
                2: press(W'($urandom), int'($urandom_range(D + 12, D + 2)), 0, 0,
                         D + 4 + int'($urandom_range(6, 0)), 1'b0);
                default: begin
                    len = D + 3 + int'($urandom_range(4, 0));
                    press(W'($urandom), len, int'($urandom_range(D - 1, 1)), int'($urandom_range(6, 1)),
                          D + 4 + int'($urandom_range(6, 0)), 1'b0);
                end
            endcase
        end
        rd_pct = 0;
        tick(2);
        drain();

        // Asynchronous reset mid-debounce with two entries queued and Button still held.
        press(16'h1111, D + 2, 0, 0, D + 4, 1'b0);
        press(16'h2222, D + 2, 0, 0, D + 4, 1'b0);
        Switches = 16'h3333;
        Button   = 1'b0;
        tick(4);
        n_reset = 1'b0;
        model_q.delete();
        push_q.delete();
        ovf_m = 1'b0;
        #1;
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_stall", stall, 0);
        check("arst_pending", pending, 0);
        check("arst_ovf", ovf, 0);
        check("arst_level", level, 0);
        tick(3);
        n_reset = 1'b1;
        push_q.push_back(push_ev_t'{cyc + 3 + D, 16'h3333});
        tick(D + 6);
        check("arst_pending_held", pending, 1);
        Button = 1'b1;
        tick(D + 4);
        check("arst_one_capture", rd_valid, 1);
        drain();
        check("arst_empty", rd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
